rf_mp_sb: RTL and testbench

Parametrised multi-port register file for the RISC-V core, with a write-tracking scoreboard. It provides two architectural read ports, two write ports, and one debug read port. Write port 0 is used by the ALU writeback and write port 1 by the load/late writeback. A busy bit per register flags writes still in flight, so decode can detect RAW hazards. Register 0 is hardwired to zero on every port.

---
 rtl/rf_mp_sb.sv | 122 ++++++++++++
 tb/tb_rf_mp_sb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_mp_sb.sv
// Multi-port register file (2R + 2W + debug read) with a per-register busy scoreboard.
// Optional macro RF_BYPASS_EN forwards same-cycle write data and busy clears to rd1/rd2/busy1/busy2.
module rf_mp_sb #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we0,
   input  logic [AW-1:0]   wa0,
   input  logic [XLEN-1:0] wd0,
   input  logic            we1,
   input  logic [AW-1:0]   wa1,
   input  logic [XLEN-1:0] wd1,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy1,
   output logic            busy2,
   input  logic            iss_v,
   input  logic [AW-1:0]   iss_rd,
   output logic [AW-1:0]   busy_cnt,
   input  logic [AW-1:0]   dbg_sel,
   output logic [XLEN-1:0] dbg_data
);

   localparam int unsigned NREG = 2 ** AW;

   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW-1:0]   busy_cnt_q, busy_cnt_d;

   // Port 1 is written after port 0 so it wins an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (we0 && (wa0 != '0)) mem_q[wa0] <= wd0;
         if (we1 && (wa1 != '0)) mem_q[wa1] <= wd1;
      end
   end

   // Issue beats a same-cycle writeback so a back-to-back reuse of rd stays tracked.
   always_comb begin
      busy_d     = busy_q;
      busy_cnt_d = '0;
      busy_d[0]  = 1'b0;
      for (int unsigned r = 1; r < NREG; r++) begin
         if (iss_v && (iss_rd == AW'(r))) begin
            busy_d[r] = 1'b1;
         end else if ((we0 && (wa0 == AW'(r))) || (we1 && (wa1 == AW'(r)))) begin
            busy_d[r] = 1'b0;
         end
         busy_cnt_d = busy_cnt_d + AW'(busy_d[r]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;
   assign dbg_data = (dbg_sel == '0) ? '0 : mem_q[dbg_sel];

   function automatic logic [XLEN-1:0] read_port(
      input logic [AW-1:0]   ra,
      input logic [XLEN-1:0] stored,
      input logic            w0,
      input logic [AW-1:0]   a0,
      input logic [XLEN-1:0] d0,
      input logic            w1,
      input logic [AW-1:0]   a1,
      input logic [XLEN-1:0] d1
   );
      logic [XLEN-1:0] val;
      val = stored;
`ifdef RF_BYPASS_EN
      if (w0 && (a0 == ra)) val = d0;
      if (w1 && (a1 == ra)) val = d1;
`else
      if (w0 && w1 && (a0 == a1) && (d0 == d1)) val = stored;
`endif
      if (ra == '0) val = '0;
      return val;
   endfunction

   function automatic logic busy_port(
      input logic [AW-1:0] ra,
      input logic          stored,
      input logic          w0,
      input logic [AW-1:0] a0,
      input logic          w1,
      input logic [AW-1:0] a1
   );
      logic b;
      b = stored;
`ifdef RF_BYPASS_EN
      if ((w0 && (a0 == ra)) || (w1 && (a1 == ra))) b = 1'b0;
`else
      if (w0 && w1 && (a0 == a1) && (a0 == ra)) b = stored;
`endif
      if (ra == '0) b = 1'b0;
      return b;
   endfunction

   always_comb begin
      rd1   = read_port(ra1, mem_q[ra1], we0, wa0, wd0, we1, wa1, wd1);
      rd2   = read_port(ra2, mem_q[ra2], we0, wa0, wd0, we1, wa1, wd1);
      busy1 = busy_port(ra1, busy_q[ra1], we0, wa0, we1, wa1);
      busy2 = busy_port(ra2, busy_q[ra2], we0, wa0, we1, wa1);
   end

endmodule

// File: tb/tb_rf_mp_sb.sv
// Scoreboard bench for rf_mp_sb: stimulus queues expected values tagged with a cycle,
// a negedge monitor pops and compares them.
module tb_rf_mp_sb;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk, rst;
   logic            we0, we1, iss_v, busy1, busy2;
   logic [AW-1:0]   wa0, wa1, ra1, ra2, iss_rd, dbg_sel, busy_cnt;
   logic [XLEN-1:0] wd0, wd1, rd1, rd2, dbg_data;

   rf_mp_sb #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .busy1(busy1), .busy2(busy2),
      .iss_v(iss_v), .iss_rd(iss_rd), .busy_cnt(busy_cnt),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   localparam int S_RD1 = 0, S_RD2 = 1, S_DBG = 2, S_B1 = 3, S_B2 = 4, S_CNT = 5;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_now(input int sig, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0;
   endtask

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_RD1:   return rd1;
         S_RD2:   return rd2;
         S_DBG:   return dbg_data;
         S_B1:    return {31'd0, busy1};
         S_B2:    return {31'd0, busy2};
         default: return {27'd0, busy_cnt};
      endcase
   endfunction

   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < q.size()) begin
         if (q[i].cyc == cyc) begin
            checks++;
            if (actual(q[i].sig) !== q[i].val) begin
               failures++;
               $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                        q[i].name, actual(q[i].sig), q[i].val, cyc);
            end
            q.delete(i);
         end else if (q[i].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation never sampled (cycle %0d)", q[i].name, q[i].cyc);
            q.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      idle();
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      ra1 = '0; ra2 = '0; iss_rd = '0; dbg_sel = '0;
      step();
      ra1 = 5; dbg_sel = 5;
      expect_now(S_RD1, 0, "reset_rd1");
      expect_now(S_CNT, 0, "reset_cnt");
      expect_now(S_DBG, 0, "reset_dbg");
      step();
      rst = 1'b0;

      // Load x5 and mark x6 busy, then reset between edges.
      we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; iss_v = 1; iss_rd = 6;
      step(); idle();
      expect_now(S_RD1, 32'hDEADBEEF, "load_x5_rd1");
      expect_now(S_CNT, 1, "load_busy_cnt");
      step();
      #1 rst = 1'b1;
      expect_now(S_RD1, 0, "async_rst_rd1");
      expect_now(S_CNT, 0, "async_rst_cnt");
      step();
      rst = 1'b0;
      expect_now(S_DBG, 0, "post_rst_dbg");
      step();

      // x0 protection.
      we0 = 1; wa0 = 0; wd0 = 32'h12345678; iss_v = 1; iss_rd = 0; ra1 = 0; dbg_sel = 0;
      expect_now(S_RD1, 0, "x0_rd1_same");
      expect_now(S_B1, 0, "x0_busy1_same");
      step(); idle();
      expect_now(S_RD1, 0, "x0_rd1");
      expect_now(S_B1, 0, "x0_busy1");
      expect_now(S_CNT, 0, "x0_cnt");
      expect_now(S_DBG, 0, "x0_dbg");
      step();

      // Write collision.
      we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h1111; wd1 = 32'h2222; ra2 = 7;
`ifdef RF_BYPASS_EN
      expect_now(S_RD2, 32'h2222, "collision_bypass_rd2");
`else
      expect_now(S_RD2, 0, "collision_old_rd2");
`endif
      step(); idle();
      dbg_sel = 7;
      expect_now(S_DBG, 32'h2222, "collision_dbg");
      expect_now(S_RD2, 32'h2222, "collision_rd2");
      step();

      // Scoreboard.
      iss_v = 1; iss_rd = 3;
      step();
      iss_rd = 9; ra1 = 3; ra2 = 9;
      expect_now(S_CNT, 1, "sb_cnt_1");
      expect_now(S_B1, 1, "sb_busy_x3");
      expect_now(S_B2, 0, "sb_x9_not_yet");
      step(); idle();
      expect_now(S_CNT, 2, "sb_cnt_2");
      expect_now(S_B2, 1, "sb_busy_x9");
      we1 = 1; wa1 = 3; wd1 = 32'h33;
`ifdef RF_BYPASS_EN
      expect_now(S_B1, 0, "wb_x3_busy1_same");
      expect_now(S_RD1, 32'h33, "wb_x3_rd1_same");
`else
      expect_now(S_B1, 1, "wb_x3_busy1_same");
`endif
      step(); idle();
      expect_now(S_B1, 0, "wb_x3_busy1");
      expect_now(S_CNT, 1, "wb_x3_cnt");
      expect_now(S_RD1, 32'h33, "wb_x3_rd1");
      we0 = 1; wa0 = 9; wd0 = 32'h99; iss_v = 1; iss_rd = 9;
`ifdef RF_BYPASS_EN
      expect_now(S_B2, 0, "wb_iss_x9_busy2_same");
`else
      expect_now(S_B2, 1, "wb_iss_x9_busy2_same");
`endif
      step(); idle();
      expect_now(S_B2, 1, "wb_iss_x9_busy2");
      expect_now(S_CNT, 1, "wb_iss_x9_cnt");
      expect_now(S_RD2, 32'h99, "wb_iss_x9_rd2");
      we0 = 1; wa0 = 9; wd0 = 32'h99;
      step(); idle();
      expect_now(S_CNT, 0, "wb_x9_cnt");
      step();

      // Bypass against an old non-zero value.
      we1 = 1; wa1 = 4; wd1 = 32'h0F0F0F0F;
      step(); idle();
      ra1 = 4; we0 = 1; wa0 = 4; wd0 = 32'hA5A5A5A5;
`ifdef RF_BYPASS_EN
      expect_now(S_RD1, 32'hA5A5A5A5, "bypass_rd1_same");
`else
      expect_now(S_RD1, 32'h0F0F0F0F, "bypass_rd1_old");
`endif
      step(); idle();
      expect_now(S_RD1, 32'hA5A5A5A5, "bypass_rd1_next");
      step();

      // Full scoreboard fill and drain.
      for (int r = 1; r < 32; r++) begin
         iss_v = 1; iss_rd = AW'(r);
         step();
         expect_now(S_CNT, r, $sformatf("fill_cnt_%0d", r));
      end
      idle();
      for (int k = 0; k < 16; k++) begin
         we0 = 1; wa0 = AW'(2 * k + 1); wd0 = 2 * k + 1;
         we1 = (k < 15); wa1 = AW'(2 * k + 2); wd1 = 2 * k + 2;
         step();
         expect_now(S_CNT, (k < 15) ? (29 - 2 * k) : 0, $sformatf("drain_cnt_%0d", k));
      end
      idle();
      dbg_sel = 31;
      expect_now(S_DBG, 31, "drain_dbg_x31");
      step();
      step();
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL leftover: got %0d pending expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
